// File: rtl/div_ctrl_if.sv
// Control-side bus of the divider sequencer.
//   start/dividend/divisor : request from the datapath (master drives)
//   busy/done/z_out/div_zero: status and result back to the control unit (slave drives)
interface div_ctrl_if;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [63:0] z_out;
  logic        div_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, z_out, div_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, z_out, div_zero
  );
endinterface

// File: rtl/div_ctrl.sv
// Sequencer between the datapath and the 32-cycle non-restoring divider.
// Latches the operands on an accepted start, holds the divider in clear for one
// cycle with the operands stable, counts LATENCY run cycles, then captures
// {remainder, quotient} into z_out and pulses done.
//
// Ports:
//   clk, resetn     : clock (rising edge), asynchronous active-low reset
//   bus (slave)     : start/dividend/divisor in; busy/done/z_out/div_zero out
//   div_resetn      : synchronous active-low clear to the divider
//   div_q, div_m    : latched dividend / divisor to the divider
//   div_quotient,
//   div_remainder   : divider results
//
// Build option: define DIV_CTRL_DZ_TRAP_EN to short-circuit a zero divisor
// straight to DONE with z_out = {dividend, 32'hFFFF_FFFF}.
module div_ctrl #(
  parameter int unsigned LATENCY = 34,
  parameter int unsigned CNT_W   = 6
) (
  input  logic        clk,
  input  logic        resetn,
  div_ctrl_if.slave   bus,
  output logic        div_resetn,
  output logic [31:0] div_q,
  output logic [31:0] div_m,
  input  logic [31:0] div_quotient,
  input  logic [31:0] div_remainder
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StClr  = 2'd1;
  localparam logic [1:0] StRun  = 2'd2;
  localparam logic [1:0] StDone = 2'd3;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0] CntMax  = '1;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [63:0]      z_q;
  logic             dz_q;
  logic [31:0]      q_q, m_q;
  logic             accept;
  logic             dz_trap;
  logic             run_last;

  // A new request is only taken when no operation is in flight.
  assign accept   = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign run_last = (state_q == StRun) && (cnt_q == CntLast);

`ifdef DIV_CTRL_DZ_TRAP_EN
  assign dz_trap = accept && (bus.divisor == 32'd0);
`else
  assign dz_trap = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = dz_trap ? StDone : StClr;
        end else begin
          state_d = StIdle;
        end
      end
      StClr:   state_d = StRun;
      StRun:   if (cnt_q == CntLast) state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      z_q     <= '0;
      dz_q    <= 1'b0;
      q_q     <= '0;
      m_q     <= '0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        q_q  <= bus.dividend;
        m_q  <= bus.divisor;
        dz_q <= 1'b0;
      end

      if (dz_trap) begin
        z_q  <= {bus.dividend, 32'hFFFF_FFFF};
        dz_q <= 1'b1;
      end

      if (state_q == StClr) begin
        cnt_q <= '0;
      end else if ((state_q == StRun) && (cnt_q != CntMax)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end

      if (run_last) begin
        z_q  <= {div_remainder, div_quotient};
        dz_q <= (m_q == 32'd0);
      end
    end
  end

  // The divider only runs in RUN; CLR gives it a clear with operands already stable.
  assign div_resetn   = (state_q == StRun);
  assign div_q        = q_q;
  assign div_m        = m_q;
  assign bus.busy     = (state_q == StClr) || (state_q == StRun);
  assign bus.done     = (state_q == StDone);
  assign bus.z_out    = z_q;
  assign bus.div_zero = dz_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl: directed cases plus randomized operations
// against a reference built from plain arithmetic and the latency rules.
module tb_div_ctrl;
  localparam int unsigned Latency = 34;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        div_resetn;
  logic [31:0] div_q, div_m, div_quotient, div_remainder;
  int unsigned rel_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  div_ctrl_if bus ();

  div_ctrl #(
    .LATENCY (Latency),
    .CNT_W   (6)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (bus),
    .div_resetn    (div_resetn),
    .div_q         (div_q),
    .div_m         (div_m),
    .div_quotient  (div_quotient),
    .div_remainder (div_remainder)
  );

  // Divider result convention: truncated signed quotient, remainder magnitude;
  // a zero divisor yields quotient all-ones and the dividend as remainder.
  function automatic logic [63:0] ref_z(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) return {a, 32'hFFFF_FFFF};
    q = sa / sb;
    r = (sa < 0 ? -sa : sa) % (sb < 0 ? -sb : sb);
    return {r[31:0], q[31:0]};
  endfunction

  // Divider stand-in: garbage until it has been out of clear long enough.
  always @(posedge clk) begin
    if (!div_resetn) rel_cnt <= 0;
    else             rel_cnt <= rel_cnt + 1;
  end

  always_comb begin
    if (rel_cnt >= Latency - 1) {div_remainder, div_quotient} = ref_z(div_q, div_m);
    else {div_remainder, div_quotient} = {32'hBAD0_0000 | rel_cnt, 32'hDEAD_BEEF};
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called #1 after an edge with the DUT idle or in DONE; returns in the DONE cycle.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input int ign_at,
                        output logic [63:0] z_seen);
    bit          trap = 1'b0;
    int          exp_j;
    int          j = 0;
    bit          ok_busy = 1'b1, ok_clr = 1'b1, ok_ops = 1'b1, ok_dz = 1'b1;
    logic [63:0] exp_z;
`ifdef DIV_CTRL_DZ_TRAP_EN
    trap = (b == 32'd0);
`endif
    exp_j = trap ? 0 : int'(Latency) + 1;
    exp_z = trap ? {a, 32'hFFFF_FFFF} : ref_z(a, b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = $urandom;
    bus.divisor  = $urandom;
    while (!bus.done && j <= exp_j + 3) begin
      if (bus.busy !== 1'b1) ok_busy = 1'b0;
      if (div_resetn !== (j >= 1)) ok_clr = 1'b0;
      if (div_q !== a || div_m !== b) ok_ops = 1'b0;
      if (bus.div_zero !== 1'b0) ok_dz = 1'b0;
      if (j == ign_at) begin
        bus.start    = 1'b1;
        bus.dividend = $urandom;
        bus.divisor  = $urandom;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      j++;
    end
    check_eq("done_latency", 64'(j), 64'(exp_j));
    check_eq("busy_while_running", 64'(ok_busy), 64'd1);
    check_eq("div_resetn_profile", 64'(ok_clr), 64'd1);
    check_eq("operands_stable", 64'(ok_ops), 64'd1);
    check_eq("div_zero_cleared", 64'(ok_dz), 64'd1);
    check_eq("done_status", {bus.done, bus.busy, div_resetn}, 3'b100);
    check_eq("z_out", bus.z_out, exp_z);
    check_eq("div_zero", 64'(bus.div_zero), 64'(b == 32'd0));
    z_seen = bus.z_out;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] z;
    bit          no_done;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;

    #12;
    check_eq("reset_ctl", {bus.busy, bus.done, bus.div_zero, div_resetn}, 4'b0000);
    check_eq("reset_z", bus.z_out, 64'd0);
    check_eq("reset_ops", {div_q, div_m}, 64'd0);
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;

    run_op(32'd38, 32'd6, -1, z);
    check_eq("z_38_6", z, 64'h00000002_00000006);
    @(posedge clk); #1;
    check_eq("done_single_pulse", {bus.done, bus.busy}, 2'b00);

    // Second start lands in the DONE cycle of the first.
    run_op(-32'sd38, 32'd6, -1, z);
    check_eq("z_m38_6", z, 64'h00000002_FFFFFFFA);
    run_op(32'd100, 32'd25, -1, z);
    check_eq("z_100_25_b2b", z, 64'h00000000_00000004);

    // A start during RUN must be ignored.
    @(posedge clk); #1;
    run_op(32'd1000, 32'd7, 10, z);
    check_eq("z_ignored_start", z, 64'h00000006_0000008E);

    // Reset pulse in the middle of RUN.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd55; bus.divisor = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (20) @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check_eq("abort_ctl", {bus.busy, bus.done, bus.div_zero, div_resetn}, 4'b0000);
    check_eq("abort_z", bus.z_out, 64'd0);
    check_eq("abort_ops", {div_q, div_m}, 64'd0);
    @(posedge clk); #3 resetn = 1'b1;
    no_done = 1'b1;
    repeat (50) begin
      @(posedge clk); #1;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) no_done = 1'b0;
    end
    check_eq("no_done_after_abort", 64'(no_done), 64'd1);
    run_op(32'd55, 32'd5, -1, z);
    check_eq("z_after_abort", z, 64'h00000000_0000000B);

    // Divide by zero (latency depends on the trap build option inside run_op).
    @(posedge clk); #1;
    run_op(32'd7, 32'd0, -1, z);
    check_eq("z_div_zero", z, 64'h00000007_FFFFFFFF);

    // Result must hold through a long idle stretch.
    @(posedge clk); #1;
    run_op(32'd1, 32'd50, -1, z);
    check_eq("z_1_50", z, 64'h00000001_00000000);
    no_done = 1'b1;
    repeat (100) begin
      @(posedge clk); #1;
      bus.dividend = $urandom;
      bus.divisor  = $urandom;
      if (bus.z_out !== 64'h00000001_00000000 || bus.done !== 1'b0) no_done = 1'b0;
    end
    check_eq("z_hold_idle", 64'(no_done), 64'd1);

    // Randomized operations with random gaps and ignored starts.
    for (int n = 0; n < 24; n++) begin
      logic [31:0] a, b;
      int          ign;
      a   = $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 :
            ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
      if ($urandom_range(0, 1) == 0) a = 32'($signed(a) >>> $urandom_range(0, 24));
      ign = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 30)) : -1;
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
      run_op(a, b, ign, z);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
